// File: rtl/csr_trap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// csr_trap_ctrl_pkg
// Shared definitions for the trap / mret CSR sequencer: bus widths, CSR
// addresses, cause codes, FSM state encoding and the mstatus rewrite helpers.
//
// Optional feature macro: CSR_TRAP_MTVAL_EN adds the W_MTVAL state encoding.
// -----------------------------------------------------------------------------
package csr_trap_ctrl_pkg;

    localparam int CsrBus     = 32;
    localparam int CsrAddrBus = 12;

    localparam logic [CsrAddrBus-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CsrAddrBus-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CsrAddrBus-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [CsrAddrBus-1:0] CSR_MTVAL   = 12'h343;

    localparam logic [CsrBus-1:0] CAUSE_ECALL  = 32'd11;
    localparam logic [CsrBus-1:0] CAUSE_EBREAK = 32'd3;
    localparam logic [CsrBus-1:0] CAUSE_TIMER  = 32'h8000_0007;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_MEPC    = 3'd1,
        W_MSTATUS = 3'd2,
        W_MCAUSE  = 3'd3,
`ifdef CSR_TRAP_MTVAL_EN
        W_MTVAL   = 3'd4,
`endif
        JUMP      = 3'd5,
        R_MSTATUS = 3'd6
    } state_e;

    // Trap entry: MPIE <- MIE, MIE <- 0.
    function automatic logic [CsrBus-1:0] trap_mstatus(input logic [CsrBus-1:0] old);
        logic [CsrBus-1:0] v;
        v    = old;
        v[7] = old[3];
        v[3] = 1'b0;
        return v;
    endfunction

    // mret: MIE <- MPIE, MPIE <- 1.
    function automatic logic [CsrBus-1:0] mret_mstatus(input logic [CsrBus-1:0] old);
        logic [CsrBus-1:0] v;
        v    = old;
        v[3] = old[7];
        v[7] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// -----------------------------------------------------------------------------
// csr_trap_ctrl
// Sequences machine-mode trap entry (ecall, ebreak, timer interrupt) and mret
// through the single CSR write port, stalls the pipeline while busy and issues
// a one-cycle redirect strobe at the end.
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   inst_addr_i            PC of the instruction in id
//   ecall_i/ebreak_i/mret_i decoded events in id
//   timer_irq_i            level timer interrupt
//   global_int_en_i        mstatus.MIE
//   csr_mtvec_i/csr_mepc_i/csr_mstatus_i  current CSR values
//   wb_we_i                wb-stage CSR write owns the port this cycle
//   csr_we_o/csr_waddr_o/csr_wdata_o      CSR write port
//   hold_o                 pipeline stall
//   int_assert_o/int_addr_o redirect strobe and target
//
// Optional feature macro: CSR_TRAP_MTVAL_EN adds an mtval write after mcause.
// -----------------------------------------------------------------------------
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CsrBus-1:0]     inst_addr_i,
    input  logic                  ecall_i,
    input  logic                  ebreak_i,
    input  logic                  mret_i,
    input  logic                  timer_irq_i,
    input  logic                  global_int_en_i,
    input  logic [CsrBus-1:0]     csr_mtvec_i,
    input  logic [CsrBus-1:0]     csr_mepc_i,
    input  logic [CsrBus-1:0]     csr_mstatus_i,
    input  logic                  wb_we_i,
    output logic                  csr_we_o,
    output logic [CsrAddrBus-1:0] csr_waddr_o,
    output logic [CsrBus-1:0]     csr_wdata_o,
    output logic                  hold_o,
    output logic                  int_assert_o,
    output logic [CsrBus-1:0]     int_addr_o
);

    state_e state, state_nxt;

    logic [CsrBus-1:0] pc_q, mstatus_q, cause_q, mepc_q;
    logic              mret_q;

    logic              irq;
    logic              take_trap, take_mret, accept;
    logic [CsrBus-1:0] cause_sel;

    // Priority ecall > ebreak > mret > interrupt.
    assign irq       = timer_irq_i & global_int_en_i;
    assign take_trap = ecall_i | ebreak_i | (irq & ~mret_i);
    assign take_mret = mret_i & ~ecall_i & ~ebreak_i;
    assign accept    = take_trap | take_mret;
    assign cause_sel = ecall_i  ? CAUSE_ECALL  :
                       ebreak_i ? CAUSE_EBREAK : CAUSE_TIMER;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc_q      <= '0;
            mstatus_q <= '0;
            cause_q   <= '0;
            mepc_q    <= '0;
            mret_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                mstatus_q <= csr_mstatus_i;
                if (take_trap) begin
                    pc_q    <= inst_addr_i;
                    cause_q <= cause_sel;
                    mret_q  <= 1'b0;
                end else begin
                    mepc_q  <= csr_mepc_i;
                    mret_q  <= 1'b1;
                end
            end
        end
    end

    // Write states only advance when the wb stage is not using the port;
    // otherwise the same write is presented again next cycle.
    always_comb begin
        state_nxt    = state;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        hold_o       = 1'b0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        case (state)
            IDLE: begin
                // rst gate keeps hold_o low while reset is asserted.
                if (accept && rst) begin
                    hold_o    = 1'b1;
                    state_nxt = take_trap ? W_MEPC : R_MSTATUS;
                end
            end
            W_MEPC: begin
                hold_o = 1'b1;
                if (!wb_we_i) begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MEPC;
                    csr_wdata_o = pc_q;
                    state_nxt   = W_MSTATUS;
                end
            end
            W_MSTATUS: begin
                hold_o = 1'b1;
                if (!wb_we_i) begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MSTATUS;
                    csr_wdata_o = trap_mstatus(mstatus_q);
                    state_nxt   = W_MCAUSE;
                end
            end
            W_MCAUSE: begin
                hold_o = 1'b1;
                if (!wb_we_i) begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MCAUSE;
                    csr_wdata_o = cause_q;
`ifdef CSR_TRAP_MTVAL_EN
                    state_nxt   = W_MTVAL;
`else
                    state_nxt   = JUMP;
`endif
                end
            end
`ifdef CSR_TRAP_MTVAL_EN
            W_MTVAL: begin
                hold_o = 1'b1;
                if (!wb_we_i) begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MTVAL;
                    csr_wdata_o = (cause_q == CAUSE_EBREAK) ? pc_q : '0;
                    state_nxt   = JUMP;
                end
            end
`endif
            R_MSTATUS: begin
                hold_o = 1'b1;
                if (!wb_we_i) begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = CSR_MSTATUS;
                    csr_wdata_o = mret_mstatus(mstatus_q);
                    state_nxt   = JUMP;
                end
            end
            JUMP: begin
                hold_o       = 1'b1;
                int_assert_o = 1'b1;
                int_addr_o   = mret_q ? mepc_q : csr_mtvec_i;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_csr_trap_ctrl
// Table of single-event vectors plus hand-written sequences (level interrupt
// re-entry, reset mid-sequence). Expected CSR writes and redirect targets are
// queued when stimulus is driven and popped by a monitor as the DUT emits them.
// -----------------------------------------------------------------------------
module tb_csr_trap_ctrl;

`ifdef CSR_TRAP_MTVAL_EN
    localparam int MT = 1;
`else
    localparam int MT = 0;
`endif

    logic        clk, rst;
    logic [31:0] inst_addr_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        ecall_i, ebreak_i, mret_i, timer_irq_i, global_int_en_i, wb_we_i;
    logic        csr_we_o, hold_o, int_assert_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o, int_addr_o;

    csr_trap_ctrl dut (
        .clk(clk), .rst(rst), .inst_addr_i(inst_addr_i),
        .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
        .timer_irq_i(timer_irq_i), .global_int_en_i(global_int_en_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
        .wb_we_i(wb_we_i), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
        .csr_wdata_o(csr_wdata_o), .hold_o(hold_o), .int_assert_o(int_assert_o),
        .int_addr_o(int_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             ecall, ebreak, mret, irq, gie;
        logic [31:0]      pc, ms, mepc, mtvec;
        int               wb_start, wb_len, lat;   // lat < 0: no activity
        logic             trap;
        logic [31:0]      mtv, tgt;
        int               nwr;
        logic [3:0][11:0] wa;
        logic [3:0][31:0] wd;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [43:0] exp_q[$];
    logic [31:0] tgt_q[$];

    // Scoreboard monitor: every write and redirect must match the queue head.
    logic [43:0] e_w;
    logic [31:0] e_t;
    always @(negedge clk) begin
        checks++;
        if (csr_we_o) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got %h=%h required none", csr_waddr_o, csr_wdata_o);
            end else begin
                e_w = exp_q.pop_front();
                if ({csr_waddr_o, csr_wdata_o} !== e_w) begin
                    errors++;
                    $display("FAIL csr_write got %h=%h required %h=%h",
                             csr_waddr_o, csr_wdata_o, e_w[43:32], e_w[31:0]);
                end
            end
        end else if (csr_waddr_o !== 12'h0 || csr_wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL idle_bus got %h=%h required 0=0", csr_waddr_o, csr_wdata_o);
        end
        checks++;
        if (int_assert_o) begin
            if (tgt_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_redirect got %h required none", int_addr_o);
            end else begin
                e_t = tgt_q.pop_front();
                if (int_addr_o !== e_t) begin
                    errors++;
                    $display("FAIL redirect_addr got %h required %h", int_addr_o, e_t);
                end
            end
        end else if (int_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL idle_int_addr got %h required 0", int_addr_o);
        end
    end

    function automatic vec_t mkv(logic e, logic b, logic m, logic i, logic g,
                                 logic [31:0] pc, logic [31:0] ms, logic [31:0] mepc, logic [31:0] mtvec,
                                 int wbs, int wbl, int lat, logic trap,
                                 logic [31:0] mtv, logic [31:0] tgt, int nwr,
                                 logic [11:0] a0, logic [31:0] d0, logic [11:0] a1, logic [31:0] d1,
                                 logic [11:0] a2, logic [31:0] d2);
        vec_t v;
        v = '0;
        v.ecall = e; v.ebreak = b; v.mret = m; v.irq = i; v.gie = g;
        v.pc = pc; v.ms = ms; v.mepc = mepc; v.mtvec = mtvec;
        v.wb_start = wbs; v.wb_len = wbl; v.lat = lat; v.trap = trap;
        v.mtv = mtv; v.tgt = tgt; v.nwr = nwr;
        v.wa[0] = a0; v.wd[0] = d0; v.wa[1] = a1; v.wd[1] = d1; v.wa[2] = a2; v.wd[2] = d2;
        return v;
    endfunction

    task automatic clear_events();
        ecall_i = 0; ebreak_i = 0; mret_i = 0; timer_irq_i = 0; global_int_en_i = 0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, int_assert_o, int_addr_o} !== '0) begin
            errors++;
            $display("FAIL %s outputs we=%b addr=%h data=%h hold=%b ia=%b ta=%h required all 0",
                     name, csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, int_assert_o, int_addr_o);
        end
    endtask

    task automatic check_queues(input string name);
        checks++;
        if (exp_q.size() != 0 || tgt_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending writes=%0d redirects=%0d required 0 0", name, exp_q.size(), tgt_q.size());
        end
        exp_q.delete();
        tgt_q.delete();
    endtask

    task automatic push_trap(input logic [31:0] pc, input logic [31:0] msw,
                             input logic [31:0] cause, input logic [31:0] mtv, input logic [31:0] tgt);
        exp_q.push_back({12'h341, pc});
        exp_q.push_back({12'h300, msw});
        exp_q.push_back({12'h342, cause});
        if (MT == 1) exp_q.push_back({12'h343, mtv});
        tgt_q.push_back(tgt);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat, lim;
        bit seen, exp_hold;
        lat = (v.lat < 0) ? -1 : v.lat + (v.trap ? MT : 0);
        lim = (lat < 0) ? 6 : lat + 1;
        @(posedge clk); #1;
        ecall_i = v.ecall; ebreak_i = v.ebreak; mret_i = v.mret;
        timer_irq_i = v.irq; global_int_en_i = v.gie;
        inst_addr_i = v.pc; csr_mstatus_i = v.ms; csr_mepc_i = v.mepc; csr_mtvec_i = v.mtvec;
        for (int k = 0; k < v.nwr; k++) exp_q.push_back({v.wa[k], v.wd[k]});
        if (v.trap && MT == 1) exp_q.push_back({12'h343, v.mtv});
        if (lat >= 0) tgt_q.push_back(v.tgt);
        seen = 0;
        for (int c = 0; c <= lim; c++) begin
            @(negedge clk);
            exp_hold = (lat >= 0) && (c <= lat);
            checks++;
            if (hold_o !== exp_hold) begin
                errors++;
                $display("FAIL vec%0d hold cycle %0d got %b required %b", idx, c, hold_o, exp_hold);
            end
            if (int_assert_o) begin
                checks++;
                if (c != lat || seen) begin
                    errors++;
                    $display("FAIL vec%0d latency got %0d required %0d", idx, c, lat);
                end
                seen = 1;
            end
            @(posedge clk); #1;
            if (c == 0) clear_events();
            wb_we_i = (c + 1 >= v.wb_start) && (c + 1 < v.wb_start + v.wb_len);
        end
        wb_we_i = 0;
        checks++;
        if (seen != (lat >= 0)) begin
            errors++;
            $display("FAIL vec%0d redirect_seen got %b required %b", idx, seen, lat >= 0);
        end
        check_queues($sformatf("vec%0d", idx));
    endtask

    vec_t tbl[10];

    initial begin
        int ia_cnt, l1, l2;
        tbl[0] = mkv(1,0,0,0,0, 32'h100, 32'h8, 32'h0, 32'h200, 0,0, 4, 1, 32'h0, 32'h200, 3,
                     12'h341,32'h100, 12'h300,32'h80, 12'h342,32'd11);
        tbl[1] = mkv(0,0,1,0,0, 32'h0, 32'h80, 32'h104, 32'h999, 0,0, 2, 0, 32'h0, 32'h104, 1,
                     12'h300,32'h88, 12'h0,32'h0, 12'h0,32'h0);
        tbl[2] = mkv(0,0,0,1,0, 32'h500, 32'h8, 32'h0, 32'h200, 0,0, -1, 0, 32'h0, 32'h0, 0,
                     12'h0,32'h0, 12'h0,32'h0, 12'h0,32'h0);
        tbl[3] = mkv(0,0,0,1,1, 32'h2000, 32'h88, 32'h0, 32'h300, 0,0, 4, 1, 32'h0, 32'h300, 3,
                     12'h341,32'h2000, 12'h300,32'h80, 12'h342,32'h8000_0007);
        tbl[4] = mkv(1,0,0,1,1, 32'h44, 32'h0, 32'h0, 32'h400, 0,0, 4, 1, 32'h0, 32'h400, 3,
                     12'h341,32'h44, 12'h300,32'h0, 12'h342,32'd11);
        tbl[5] = mkv(0,1,0,0,0, 32'h40, 32'h808, 32'h0, 32'h500, 0,0, 4, 1, 32'h40, 32'h500, 3,
                     12'h341,32'h40, 12'h300,32'h880, 12'h342,32'd3);
        tbl[6] = mkv(1,0,0,0,0, 32'h100, 32'h8, 32'h0, 32'h200, 2,2, 6, 1, 32'h0, 32'h200, 3,
                     12'h341,32'h100, 12'h300,32'h80, 12'h342,32'd11);
        tbl[7] = mkv(0,0,1,0,0, 32'h0, 32'hFFFF_FFF7, 32'h80, 32'hABC, 0,0, 2, 0, 32'h0, 32'h80, 1,
                     12'h300,32'hFFFF_FFFF, 12'h0,32'h0, 12'h0,32'h0);
        tbl[8] = mkv(0,1,1,0,0, 32'h60, 32'h0, 32'h70, 32'h600, 0,0, 4, 1, 32'h60, 32'h600, 3,
                     12'h341,32'h60, 12'h300,32'h0, 12'h342,32'd3);
        tbl[9] = mkv(0,0,1,1,1, 32'h0, 32'h80, 32'h10, 32'h700, 0,0, 2, 0, 32'h0, 32'h10, 1,
                     12'h300,32'h88, 12'h0,32'h0, 12'h0,32'h0);

        // Reset with an event pending: everything stays quiet.
        rst = 0; wb_we_i = 0; clear_events(); ecall_i = 1;
        inst_addr_i = 32'h100; csr_mstatus_i = 32'h8; csr_mepc_i = 0; csr_mtvec_i = 32'h200;
        repeat (2) begin @(negedge clk); check_all_zero("reset"); end
        @(posedge clk); #1; rst = 1; clear_events();

        for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

        // Level interrupt held: re-taken on return to IDLE; a mret pulse
        // while busy is ignored.
        @(posedge clk); #1;
        timer_irq_i = 1; global_int_en_i = 1;
        inst_addr_i = 32'h300; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h700;
        push_trap(32'h300, 32'h80, 32'h8000_0007, 32'h0, 32'h700);
        push_trap(32'h300, 32'h80, 32'h8000_0007, 32'h0, 32'h700);
        l1 = 4 + MT; l2 = 2 * l1 + 1; ia_cnt = 0;
        for (int c = 0; c <= l2; c++) begin
            @(negedge clk);
            checks++;
            if (hold_o !== 1'b1) begin
                errors++;
                $display("FAIL irq_level hold cycle %0d got %b required 1", c, hold_o);
            end
            if (int_assert_o) begin
                checks++;
                if (!((ia_cnt == 0 && c == l1) || (ia_cnt == 1 && c == l2))) begin
                    errors++;
                    $display("FAIL irq_level redirect cycle %0d got #%0d required %0d/%0d", c, ia_cnt, l1, l2);
                end
                ia_cnt++;
            end
            @(posedge clk); #1;
            mret_i = (c == 1);
        end
        clear_events();
        @(negedge clk);
        checks++;
        if (hold_o !== 1'b0 || ia_cnt != 2) begin
            errors++;
            $display("FAIL irq_level end hold=%b redirects=%0d required 0 2", hold_o, ia_cnt);
        end
        check_queues("irq_level");

        // Reset during W_MCAUSE abandons the sequence; ecall on release is
        // accepted at the first edge.
        @(posedge clk); #1;
        ecall_i = 1; inst_addr_i = 32'h100; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h200;
        exp_q.push_back({12'h341, 32'h100});
        exp_q.push_back({12'h300, 32'h80});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            @(posedge clk); #1;
            clear_events();
        end
        rst = 0; ecall_i = 1;
        repeat (2) begin @(negedge clk); check_all_zero("mid_reset"); end
        check_queues("mid_reset");
        @(posedge clk); #1;
        rst = 1;
        push_trap(32'h100, 32'h80, 32'd11, 32'h0, 32'h200);
        ia_cnt = 0;
        for (int c = 0; c <= 5 + MT; c++) begin
            @(negedge clk);
            checks++;
            if (hold_o !== (c <= 4 + MT)) begin
                errors++;
                $display("FAIL post_reset hold cycle %0d got %b required %b", c, hold_o, c <= 4 + MT);
            end
            if (int_assert_o) begin
                checks++;
                if (c != 4 + MT) begin
                    errors++;
                    $display("FAIL post_reset latency got %0d required %0d", c, 4 + MT);
                end
                ia_cnt++;
            end
            @(posedge clk); #1;
            clear_events();
        end
        checks++;
        if (ia_cnt != 1) begin
            errors++;
            $display("FAIL post_reset redirects got %0d required 1", ia_cnt);
        end
        check_queues("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
